// File: rtl/if_id_pipe.sv
// IF->ID pipeline register: valid/ready both sides, optional 2-entry skid, flush, byte swap, stall counter.
// One-cycle latency, no comb if->id path; SKID=1 gives a registered if_ready, SKID=0 a combinational one.
module if_id_pipe #(
  parameter int                ADDR_W     = 32,
  parameter int                INST_W     = 32,
  parameter bit                SWAP_BYTES = 1'b1,
  parameter bit                SKID       = 1'b1,
  parameter logic [INST_W-1:0] NOP_INST   = 32'h00000013,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] s_pc;
  logic [INST_W-1:0] s_inst;
  logic [INST_W-1:0] cap_inst;
  logic              accept, issue;
  logic              load_m, load_s, m_from_s;
  logic              stall_inc;

  assign id_valid = (state != EMPTY);
  assign accept   = if_valid & if_ready;
  assign issue    = id_valid & id_ready;

  generate
    if (SKID) begin : g_rdy_skid
      // Only depends on state, so if_ready is effectively a register output.
      assign if_ready = !rst && (state != TWO);
    end else begin : g_rdy_single
      assign if_ready = !rst && (!id_valid || id_ready);
    end

    if (SWAP_BYTES) begin : g_swap
      for (genvar i = 0; i < INST_W / 8; i++) begin : g_lane
        assign cap_inst[8*i +: 8] = if_inst[INST_W-8-8*i +: 8];
      end
    end else begin : g_pass
      assign cap_inst = if_inst;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_m    = 1'b0;
    load_s    = 1'b0;
    m_from_s  = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            load_m    = 1'b1;
          end
        end
        ONE: begin
          if (issue && accept) begin
            load_m = 1'b1;
          end else if (issue) begin
            state_nxt = EMPTY;
          end else if (accept && SKID) begin
            state_nxt = TWO;
            load_s    = 1'b1;
          end
        end
        TWO: begin
          if (issue) begin
            state_nxt = ONE;
            m_from_s  = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // id_pc deliberately holds across flush and drain; only id_inst snaps to NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc   <= '0;
      id_inst <= NOP_INST;
      s_pc    <= '0;
      s_inst  <= NOP_INST;
    end else begin
      if (state_nxt == EMPTY) begin
        id_inst <= NOP_INST;
      end else if (load_m) begin
        id_pc   <= if_pc;
        id_inst <= cap_inst;
      end else if (m_from_s) begin
        id_pc   <= s_pc;
        id_inst <= s_inst;
      end
      if (load_s) begin
        s_pc   <= if_pc;
        s_inst <= cap_inst;
      end
    end
  end

  assign stall_inc = id_valid & !id_ready & !flush & (stall_cnt != {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst || stall_clr)  stall_cnt <= '0;
    else if (stall_inc)    stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed bench for if_id_pipe: skid/swap instance (a) and single-entry/pass-through CNT_W=4 instance (b).
`timescale 1ns/1ps
module tb_if_id_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_if_valid, a_if_ready, a_flush, a_id_valid, a_id_ready, a_stall_clr;
  logic [31:0] a_if_pc, a_if_inst, a_id_pc, a_id_inst;
  logic [15:0] a_stall_cnt;
  logic        b_if_valid, b_if_ready, b_flush, b_id_valid, b_id_ready, b_stall_clr;
  logic [31:0] b_if_pc, b_if_inst, b_id_pc, b_id_inst;
  logic [3:0]  b_stall_cnt;

  if_id_pipe #(.SKID(1'b1), .SWAP_BYTES(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst),
    .if_valid(a_if_valid), .if_ready(a_if_ready), .if_pc(a_if_pc), .if_inst(a_if_inst),
    .flush(a_flush),
    .id_valid(a_id_valid), .id_ready(a_id_ready), .id_pc(a_id_pc), .id_inst(a_id_inst),
    .stall_cnt(a_stall_cnt), .stall_clr(a_stall_clr)
  );

  if_id_pipe #(.SKID(1'b0), .SWAP_BYTES(1'b0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst),
    .if_valid(b_if_valid), .if_ready(b_if_ready), .if_pc(b_if_pc), .if_inst(b_if_inst),
    .flush(b_flush),
    .id_valid(b_id_valid), .id_ready(b_id_ready), .id_pc(b_id_pc), .id_inst(b_id_inst),
    .stall_cnt(b_stall_cnt), .stall_clr(b_stall_clr)
  );

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Scoreboards: push on accept, pop on issue, drop everything on flush/reset.
  ent_t qa[$];
  ent_t qb[$];

  always @(negedge clk) begin
    ent_t e;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_id_valid && a_id_ready) begin
        chk("a_issue_expected", qa.size() > 0, 1'b1);
        if (qa.size() > 0) begin
          e = qa.pop_front();
          chk("a_sb_pc", a_id_pc, e.pc);
          chk("a_sb_inst", a_id_inst, e.inst);
        end
      end
      if (a_flush) qa.delete();
      else if (a_if_valid && a_if_ready) qa.push_back({a_if_pc, bswap(a_if_inst)});

      if (b_id_valid && b_id_ready) begin
        chk("b_issue_expected", qb.size() > 0, 1'b1);
        if (qb.size() > 0) begin
          e = qb.pop_front();
          chk("b_sb_pc", b_id_pc, e.pc);
          chk("b_sb_inst", b_id_inst, e.inst);
        end
      end
      if (b_flush) qb.delete();
      else if (b_if_valid && b_if_ready) qb.push_back({b_if_pc, b_if_inst});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] prev_pc;
    rst = 1'b1;
    a_if_valid = 1'b0; a_if_pc = '0; a_if_inst = '0; a_flush = 1'b0; a_id_ready = 1'b0; a_stall_clr = 1'b0;
    b_if_valid = 1'b0; b_if_pc = '0; b_if_inst = '0; b_flush = 1'b0; b_id_ready = 1'b0; b_stall_clr = 1'b0;
    prev_pc = '0;

    // reset
    @(negedge clk);
    chk("rst_if_ready_low", a_if_ready, 1'b0);
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_id_valid", a_id_valid, 1'b0);
    chk("rst_id_pc", a_id_pc, 32'h0);
    chk("rst_id_inst", a_id_inst, 32'h00000013);
    chk("rst_stall_cnt", a_stall_cnt, 16'd0);
    chk("rst_if_ready_high", a_if_ready, 1'b1);
    chk("rst_b_if_ready", b_if_ready, 1'b1);
    tick();

    // streaming with byte swap
    a_id_ready = 1'b1; a_if_valid = 1'b1; a_if_pc = 32'h100; a_if_inst = 32'h13000000;
    @(negedge clk);
    chk("stream_if_ready0", a_if_ready, 1'b1);
    tick();
    a_if_pc = 32'h104; a_if_inst = 32'h93001000;
    @(negedge clk);
    chk("stream_valid1", a_id_valid, 1'b1);
    chk("stream_pc1", a_id_pc, 32'h100);
    chk("stream_inst1", a_id_inst, 32'h00000013);
    chk("stream_if_ready1", a_if_ready, 1'b1);
    tick();
    a_if_valid = 1'b0;
    @(negedge clk);
    chk("stream_pc2", a_id_pc, 32'h104);
    chk("stream_inst2", a_id_inst, 32'h00100093);
    tick();
    @(negedge clk);
    chk("stream_empty_valid", a_id_valid, 1'b0);
    chk("stream_empty_nop", a_id_inst, 32'h00000013);
    tick();

    // back-pressure into the skid entry
    a_id_ready = 1'b0; a_if_valid = 1'b1; a_if_pc = 32'h100; a_if_inst = 32'h13000000;
    @(negedge clk);
    tick();
    a_if_pc = 32'h104; a_if_inst = 32'h93001000;
    @(negedge clk);
    chk("bp_if_ready_one", a_if_ready, 1'b1);
    tick();
    a_if_pc = 32'h108; a_if_inst = 32'h12345678;
    repeat (3) begin
      @(negedge clk);
      chk("bp_if_ready_two", a_if_ready, 1'b0);
      chk("bp_pc_stable", a_id_pc, 32'h100);
      tick();
    end
    a_if_valid = 1'b0; a_id_ready = 1'b1;
    @(negedge clk);
    chk("bp_stall_cnt", a_stall_cnt, 16'd4);
    tick();
    for (int i = 0; i < 10 && qa.size() != 0; i++) tick();
    chk("bp_drain", qa.size(), 0);
    chk("bp_empty", a_id_valid, 1'b0);

    // flush while holding two words
    a_id_ready = 1'b0; a_if_valid = 1'b1; a_if_pc = 32'h200; a_if_inst = 32'haabbccdd;
    @(negedge clk);
    tick();
    a_if_pc = 32'h204; a_if_inst = 32'h11223344;
    @(negedge clk);
    tick();
    a_if_pc = 32'h108; a_if_inst = 32'h12345678; a_flush = 1'b1;
    @(negedge clk);
    chk("fl_two_if_ready", a_if_ready, 1'b0);
    tick();
    a_flush = 1'b0; a_if_valid = 1'b0;
    @(negedge clk);
    chk("fl_valid", a_id_valid, 1'b0);
    chk("fl_nop", a_id_inst, 32'h00000013);
    chk("fl_if_ready", a_if_ready, 1'b1);
    chk("fl_pc_hold", a_id_pc, 32'h200);
    chk("fl_stall_cnt", a_stall_cnt, 16'd5);
    tick();

    // flush discards a same-cycle accept
    a_if_valid = 1'b1; a_if_pc = 32'h300; a_if_inst = 32'h01020304;
    @(negedge clk);
    tick();
    a_if_pc = 32'h304; a_if_inst = 32'h05060708; a_flush = 1'b1;
    @(negedge clk);
    chk("fl_acc_if_ready", a_if_ready, 1'b1);
    tick();
    a_flush = 1'b0; a_if_valid = 1'b0;
    @(negedge clk);
    chk("fl_acc_valid", a_id_valid, 1'b0);
    chk("fl_acc_pc", a_id_pc, 32'h300);
    chk("fl_acc_stall", a_stall_cnt, 16'd5);
    tick();
    a_stall_clr = 1'b1;
    tick();
    a_stall_clr = 1'b0;
    @(negedge clk);
    chk("clr_idle", a_stall_cnt, 16'd0);
    tick();

    // flush and reset together
    a_if_valid = 1'b1; a_if_pc = 32'h500; a_if_inst = 32'hdeadbeef;
    @(negedge clk);
    tick();
    a_if_pc = 32'h504;
    @(negedge clk);
    tick();
    rst = 1'b1; a_flush = 1'b1;
    @(negedge clk);
    chk("rfl_if_ready", a_if_ready, 1'b0);
    tick();
    rst = 1'b0; a_flush = 1'b0; a_if_valid = 1'b0;
    @(negedge clk);
    chk("rfl_valid", a_id_valid, 1'b0);
    chk("rfl_pc", a_id_pc, 32'h0);
    chk("rfl_inst", a_id_inst, 32'h00000013);
    chk("rfl_stall", a_stall_cnt, 16'd0);
    chk("rfl_if_ready_after", a_if_ready, 1'b1);
    tick();

    // single entry, pass-through: one word per cycle
    b_id_ready = 1'b1; b_if_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_if_pc = 32'h400 + 32'(4 * i);
      b_if_inst = $urandom;
      @(negedge clk);
      chk("b_stream_if_ready", b_if_ready, 1'b1);
      if (i > 0) begin
        chk("b_stream_valid", b_id_valid, 1'b1);
        chk("b_stream_pc", b_id_pc, prev_pc);
      end
      prev_pc = b_if_pc;
      tick();
    end
    b_if_valid = 1'b0;
    @(negedge clk);
    chk("b_last_valid", b_id_valid, 1'b1);
    tick();
    for (int i = 0; i < 10 && qb.size() != 0; i++) tick();
    chk("b_drain1", qb.size(), 0);

    // combinational if_ready follows id_ready
    b_if_valid = 1'b1; b_if_pc = 32'h600; b_if_inst = 32'hcafef00d;
    @(negedge clk);
    tick();
    b_id_ready = 1'b0; b_if_pc = 32'h604; b_if_inst = 32'h0badf00d;
    @(negedge clk);
    chk("b_if_ready_low", b_if_ready, 1'b0);
    tick();
    b_id_ready = 1'b1;
    #1;
    chk("b_if_ready_comb", b_if_ready, 1'b1);
    @(negedge clk);
    tick();

    // saturation and clear-during-stall
    b_id_ready = 1'b0; b_if_valid = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    chk("b_sat", b_stall_cnt, 4'd15);
    chk("b_sat_pc", b_id_pc, 32'h604);
    b_stall_clr = 1'b1;
    tick();
    b_stall_clr = 1'b0;
    @(negedge clk);
    chk("b_clr_wins", b_stall_cnt, 4'd0);
    tick();
    chk("b_count_after_clr", b_stall_cnt, 4'd1);
    b_id_ready = 1'b1;
    for (int i = 0; i < 10 && qb.size() != 0; i++) tick();
    chk("b_drain2", qb.size(), 0);
    chk("b_empty_nop", b_id_inst, 32'h00000013);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
